game_tick_scheduler: RTL
========================

// Module: game_tick_scheduler
// PURPOSE
//  Owns the game's timing. A programmable period counter derives game ticks from CLOCK_50.
//  Each accepted tick launches a sequence of three phase strobes (INPUT, UPDATE, RENDER) to the
//  game datapath, with a done handshake on each phase. Supports start/stop/pause/single-step
//  and speed levels. Sits between CLOCK_50 and the game logic.
// PARAMETERS
//  CNT_W        28         period counter width
//  BASE_PERIOD  4_000_000  CLOCK_50 cycles per tick at level 0
//  LEVEL_STEP   250_000    cycles removed from the period per speed level
//  MIN_PERIOD   500_000    floor on the period (must be >= 2)
//  NUM_LEVELS   8          number of speed levels; level saturates at NUM_LEVELS-1
// PORTS
//  CLOCK_50      in   1   system clock
//  RESET         in   1   asynchronous, active-high reset
//  start         in   1   1-cycle pulse; IDLE -> RUN
//  stop          in   1   1-cycle pulse; any state -> IDLE, aborts the phase sequence
//  pause         in   1   1-cycle pulse; toggles RUN <-> PAUSED
//  step          in   1   1-cycle pulse; in PAUSED, issues exactly one tick
//  speed_up      in   1   1-cycle pulse; level+1, saturating
//  stage_done    in   1   datapath acknowledge for the active phase
//  tick          out  1   1-cycle pulse per accepted tick
//  game_clk      out  1   toggles on every accepted tick
//  phase_input   out  1   one-hot phase strobe; held until stage_done
//  phase_update  out  1   one-hot phase strobe; held until stage_done
//  phase_render  out  1   one-hot phase strobe; held until stage_done
//  level         out  3   current speed level
//  running       out  1   1 in RUN or PAUSED
//  overrun       out  1   sticky; a tick expired while the sequencer was busy
//  tick_count    out  16  accepted ticks since start; wraps at 0xFFFF -> 0
// BEHAVIOUR
//  - RESET: all outputs 0, level 0, control FSM IDLE, sequencer S_IDLE, counter 0.
//  - Period: P = max(BASE_PERIOD - level*LEVEL_STEP, MIN_PERIOD).
//    Compute at CNT_W+4 bits, signed-safe; a negative result clamps to MIN_PERIOD.
//  - Counter: loads P-1, decrements to 0, then expires and reloads P-1 on the same edge.
//    A level change takes effect at the next reload only.
//  - Control FSM:
//    - IDLE -start-> RUN: counter loads P-1; tick_count, overrun and level are cleared.
//    - RUN -pause-> PAUSED: counter frozen, remaining count preserved.
//    - PAUSED -pause-> RUN: counting resumes from the preserved value.
//    - stop -> IDLE from any state; all phase outputs drop on the next edge.
//  - Priority of same-cycle commands: stop > start > pause > step.
//    A command that is illegal in the current state is ignored.
//  - Tick acceptance: tick candidates are counter expiry in RUN, or step in PAUSED.
//    - The sequencer is free if it is in S_IDLE, or in S_RENDER with stage_done=1
//      (back-to-back acceptance).
//    - Free: on the next edge, tick=1 for one cycle, game_clk toggles, tick_count++,
//      phase_input=1.
//    - Busy: the tick is dropped, overrun is set, tick_count is unchanged.
//  - Sequencer S_IDLE -> S_INPUT -> S_UPDATE -> S_RENDER -> S_IDLE.
//    - Each advance happens on the edge where stage_done=1 in that state.
//    - Exactly one phase output is high in each non-idle state.
//    - stage_done in S_IDLE is ignored.
//  - step in RUN, pause in IDLE, start while running: ignored.
//    step in PAUSED does not touch the counter.
//  - speed_up is accepted in any state, including IDLE.
//  - overrun clears only on RESET or start.
// STRUCTURE
//  - Package game_timing_pkg: control state encodings (IDLE/RUN/PAUSED), phase encodings
//    (S_IDLE/S_INPUT/S_UPDATE/S_RENDER), default period constants.
//  - Sub-module tick_divider: loadable down-counter with hold and expiry pulse,
//    ports (CLOCK_50, RESET, load, load_val, hold, expire).
//  - Period computation, control FSM and sequencer live in this module.
// TESTING  (bench params: BASE_PERIOD=20, LEVEL_STEP=4, MIN_PERIOD=8)
//  1. start, stage_done tied 1 -> tick every 20 cycles; game_clk toggles each tick;
//     tick_count 1,2,3; each phase high 1 cycle.
//  2. speed_up x2 -> period 12 from the next reload; x5 more -> level 7, period clamps to 8;
//     further speed_up leaves level at 7.
//  3. pause with 7 cycles remaining, hold 50 cycles, pause again -> next tick 7 cycles later;
//     no ticks while paused.
//  4. In PAUSED: step -> one tick plus a full 3-phase sequence, counter unchanged.
//     step in RUN -> no effect. stop+start in the same cycle -> IDLE.
//  5. stage_done held 0 during phase_update across an expiry -> overrun=1, tick_count
//     unchanged. Expiry coincident with render stage_done -> tick accepted, overrun stays 0.
//  6. RESET asserted mid-S_UPDATE, between clock edges -> all outputs 0 immediately.
//     After release, start is required before any further tick.

Source files
------------

// File: rtl/game_timing_pkg.sv
// Shared encodings and default timing constants for the game tick scheduler.
// Parameter defaults assume a 50 MHz clock.
package game_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INPUT  = 2'd1,
    S_UPDATE = 2'd2,
    S_RENDER = 2'd3
  } phase_e;

  localparam int DEF_CNT_W       = 28;
  localparam int DEF_BASE_PERIOD = 4_000_000;
  localparam int DEF_LEVEL_STEP  = 250_000;
  localparam int DEF_MIN_PERIOD  = 500_000;
  localparam int DEF_NUM_LEVELS  = 8;

  localparam int LEVEL_W = 3;
  localparam int TCNT_W  = 16;

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Command, phase-handshake and status bundle between the scheduler and the game logic.
// The master drives commands and stage_done; the scheduler (slave) drives everything else.
interface game_tick_scheduler_if;
  import game_timing_pkg::*;

  logic                start;
  logic                stop;
  logic                pause;
  logic                step;
  logic                speed_up;
  logic                stage_done;

  logic                tick;
  logic                game_clk;
  logic                phase_input;
  logic                phase_update;
  logic                phase_render;
  logic [LEVEL_W-1:0]  level;
  logic                running;
  logic                overrun;
  logic [TCNT_W-1:0]   tick_count;

  modport master (
    output start, stop, pause, step, speed_up, stage_done,
    input  tick, game_clk, phase_input, phase_update, phase_render,
    input  level, running, overrun, tick_count
  );

  modport slave (
    input  start, stop, pause, step, speed_up, stage_done,
    output tick, game_clk, phase_input, phase_update, phase_render,
    output level, running, overrun, tick_count
  );

endinterface

// File: rtl/tick_divider.sv
// Loadable down-counter: reloads load_val after reaching zero and flags expiry
// combinationally during the zero cycle; hold freezes the count.
module tick_divider #(
  parameter int CNT_W = 28
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_zero;

  assign at_zero = (cnt_q == '0);
  assign expire  = at_zero && !hold;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold) begin
      // load_val is sampled only at reload, so a period change waits for the next expiry
      cnt_d = at_zero ? load_val : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timing owner: derives ticks from a level-dependent period, runs the
// start/stop/pause/step control FSM and the INPUT/UPDATE/RENDER phase sequencer.
module game_tick_scheduler
  import game_timing_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int LEVEL_STEP  = DEF_LEVEL_STEP,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int NUM_LEVELS  = DEF_NUM_LEVELS
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  game_tick_scheduler_if.slave bus
);

  localparam int                 PW      = CNT_W + 4;
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(NUM_LEVELS - 1);

  ctrl_state_e         ctrl_q, ctrl_d;
  phase_e              seq_q, seq_d;
  logic [LEVEL_W-1:0]  level_q, level_d, level_eff;
  logic [TCNT_W-1:0]   tick_count_q;
  logic                tick_q, game_clk_q, running_q, overrun_q;
  logic                ph_input_q, ph_update_q, ph_render_q;

  logic                do_start, do_pause, do_step;
  logic                cand, seq_free, accept;
  logic                expire;
  logic signed [PW-1:0] prod_s, diff_s;
  logic [CNT_W-1:0]    period, load_val;

  // Command decode: stop overrides everything, pause beats step while PAUSED.
  always_comb begin
    do_start = bus.start && !bus.stop && (ctrl_q == IDLE);
    do_pause = bus.pause && !bus.stop && (ctrl_q != IDLE);
    do_step  = bus.step && !bus.stop && !bus.pause && (ctrl_q == PAUSED);
    cand     = !bus.stop && (((ctrl_q == RUN) && expire) || do_step);
    seq_free = (seq_q == S_IDLE) || ((seq_q == S_RENDER) && bus.stage_done);
    accept   = cand && seq_free;
  end

  // The start edge loads the counter as if the level were already cleared.
  always_comb begin
    level_eff = do_start ? '0 : level_q;
    prod_s    = $signed(PW'(level_eff)) * $signed(PW'(LEVEL_STEP));
    diff_s    = $signed(PW'(BASE_PERIOD)) - prod_s;
    if (diff_s < $signed(PW'(MIN_PERIOD))) begin
      period = CNT_W'(MIN_PERIOD);
    end else begin
      period = diff_s[CNT_W-1:0];
    end
    load_val = period - CNT_W'(1);
  end

  tick_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .load     (do_start),
    .load_val (load_val),
    .hold     (ctrl_q != RUN),
    .expire   (expire)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    if (bus.stop) begin
      ctrl_d = IDLE;
    end else if (do_start) begin
      ctrl_d = RUN;
    end else if (do_pause) begin
      ctrl_d = (ctrl_q == RUN) ? PAUSED : RUN;
    end
  end

  always_comb begin
    level_d = do_start ? '0 : level_q;
    if (bus.speed_up && (level_d < LVL_MAX)) begin
      level_d = level_d + LEVEL_W'(1);
    end
  end

  always_comb begin
    seq_d = seq_q;
    if (bus.stop) begin
      seq_d = S_IDLE;
    end else begin
      case (seq_q)
        S_IDLE:   if (accept)         seq_d = S_INPUT;
        S_INPUT:  if (bus.stage_done) seq_d = S_UPDATE;
        S_UPDATE: if (bus.stage_done) seq_d = S_RENDER;
        // A tick landing on the render acknowledge restarts the sequence directly.
        S_RENDER: if (bus.stage_done) seq_d = accept ? S_INPUT : S_IDLE;
        default:                      seq_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      ctrl_q       <= IDLE;
      seq_q        <= S_IDLE;
      level_q      <= '0;
      tick_q       <= 1'b0;
      game_clk_q   <= 1'b0;
      tick_count_q <= '0;
      overrun_q    <= 1'b0;
      running_q    <= 1'b0;
      ph_input_q   <= 1'b0;
      ph_update_q  <= 1'b0;
      ph_render_q  <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      seq_q        <= seq_d;
      level_q      <= level_d;
      tick_q       <= accept;
      game_clk_q   <= game_clk_q ^ accept;
      tick_count_q <= do_start ? '0 : tick_count_q + TCNT_W'(accept);
      overrun_q    <= do_start ? 1'b0 : (overrun_q | (cand && !seq_free));
      running_q    <= (ctrl_d != IDLE);
      ph_input_q   <= (seq_d == S_INPUT);
      ph_update_q  <= (seq_d == S_UPDATE);
      ph_render_q  <= (seq_d == S_RENDER);
    end
  end

  assign bus.tick         = tick_q;
  assign bus.game_clk     = game_clk_q;
  assign bus.phase_input  = ph_input_q;
  assign bus.phase_update = ph_update_q;
  assign bus.phase_render = ph_render_q;
  assign bus.level        = level_q;
  assign bus.running      = running_q;
  assign bus.overrun      = overrun_q;
  assign bus.tick_count   = tick_count_q;

endmodule
